// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, issues one 32-bit fetch at a time over a
// request/response bus, and presents one instruction at a time to decode
// through a valid/ready handshake.
// Execute can redirect the PC at any time. A redirect while a fetch is in flight
// kills that fetch. The killed response is drained and dropped before the next
// fetch is issued, so at most one request is ever outstanding.
module ysyx_23060096_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request channel
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  // instruction memory response channel
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  // PC redirect from execute (branch / jump / trap)
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // instruction slot towards decode / ImmGen
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  // canonical NOP (addi x0, x0, 0) used for faulting slots and after reset
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // issue a fetch for pcReg (or drain a killed response)
    WAIT = 2'd1,  // one request outstanding, waiting for its response
    HOLD = 2'd2   // instruction presented to decode
  } ifuState;

  ifuState     stateReg;
  logic [31:0] pcReg;
  logic        killReg;     // a dropped request still has a response in flight
  logic [31:0] outPcReg;
  logic [31:0] outInstReg;
  logic        outFaultReg;

  logic pcAligned;
  logic reqFire;

  assign pcAligned = (pcReg[1:0] == 2'b00);

  // A request goes out only from REQ with an aligned PC and no killed response
  // still in flight. It is held low during reset.
  assign imem_req_valid = !rst && (stateReg == REQ) && !killReg && pcAligned;
  assign imem_req_addr  = pcReg;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign out_valid = !rst && (stateReg == HOLD);
  assign out_pc    = outPcReg;
  assign out_inst  = outInstReg;
  assign out_fault = outFaultReg;

  // Fetch FSM: PC, kill flag and the presented instruction slot
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= REQ;
      pcReg       <= RESET_PC;
      killReg     <= 1'b0;
      outPcReg    <= RESET_PC;
      outInstReg  <= NOP_INST;
      outFaultReg <= 1'b0;
    end else begin
      case (stateReg)
        REQ: begin
          // The response of a killed request ends the kill.
          // That response never reaches decode.
          if (killReg && imem_resp_valid) begin
            killReg <= 1'b0;
          end
          if (redirect_valid) begin
            // Stay here on the new PC. A request that fired in this same
            // cycle belongs to the old stream, so its response is killed.
            pcReg <= redirect_pc;
            if (reqFire) begin
              killReg <= 1'b1;
            end
          end else if (!killReg) begin
            if (!pcAligned) begin
              // Misaligned PC: skip the bus and present a fault slot directly
              stateReg    <= HOLD;
              outPcReg    <= pcReg;
              outInstReg  <= NOP_INST;
              outFaultReg <= 1'b1;
            end else if (reqFire) begin
              stateReg <= WAIT;
            end
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            // Go back to REQ on the new PC. If the response has not come
            // in yet, mark it to be dropped when it does arrive. If it
            // arrives in this very cycle, it is simply discarded here.
            pcReg    <= redirect_pc;
            stateReg <= REQ;
            killReg  <= !imem_resp_valid;
          end else if (imem_resp_valid) begin
            stateReg    <= HOLD;
            outPcReg    <= pcReg;
            outInstReg  <= imem_resp_err ? NOP_INST : imem_resp_data;
            outFaultReg <= imem_resp_err;
          end
        end

        HOLD: begin
          // A redirect beats a consume in the same cycle, so the PC is
          // not stepped.
          if (redirect_valid) begin
            pcReg    <= redirect_pc;
            stateReg <= REQ;
          end else if (out_ready) begin
            pcReg    <= pcReg + 32'd4;
            stateReg <= REQ;
          end
        end

        default: begin
          stateReg <= REQ;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060096_ifu.md
YSYX_23060096_IFU -- requirements
Module: ysyx_23060096_IFU

Purpose: instruction fetch stage. Holds PC, fetches 32-bit words over a request/response memory handshake, presents one instruction at a time to decode/ImmGen with a valid/ready handshake, and accepts PC redirects from execute.

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-004 imem_req_valid, output, 1: fetch request present.
REQ-005 imem_req_ready, input, 1: memory accepts the request.
REQ-006 imem_req_addr, output, 32: fetch address, equal to the current PC.
REQ-007 imem_resp_valid, input, 1: response word valid (single-cycle pulse).
REQ-008 imem_resp_data, input, 32: fetched instruction word.
REQ-009 imem_resp_err, input, 1: access fault, qualified by imem_resp_valid.
REQ-010 redirect_valid, input, 1: replace the PC with redirect_pc (branch/jump/trap).
REQ-011 redirect_pc, input, 32: redirect target.
REQ-012 out_valid, output, 1: instruction available to decode.
REQ-013 out_ready, input, 1: decode consumes the instruction.
REQ-014 out_pc, output, 32: PC of the presented instruction.
REQ-015 out_inst, output, 32: presented instruction word; bits [31:7] feed the 25-bit ImmGen inst input directly.
REQ-016 out_fault, output, 1: presented slot is a fetch fault (bus error or misaligned PC).

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD.
REQ-018 REQ: imem_req_valid=1 and imem_req_addr=PC; on imem_req_ready, go to WAIT.
REQ-019 WAIT: imem_req_valid=0; on imem_resp_valid, latch data and err into the output register, keep out_pc=PC, and go to HOLD.
REQ-020 HOLD: out_valid=1 and outputs stable until out_valid&&out_ready; on that cycle PC<=PC+4 (mod 2^32, wrap to 0) and state<=REQ.
REQ-021 out_valid SHALL be 1 only in HOLD; minimum fetch-to-fetch latency is 3 cycles (REQ fire, response, consume) with a zero-wait memory.
REQ-022 imem_req_addr SHALL be sampled by memory only on a req fire; it may change in REQ while imem_req_ready=0.
REQ-023 Redirect in REQ: PC<=redirect_pc; stay in REQ, even if req fires in that same cycle (the fired request is killed as in REQ-024).
REQ-024 Redirect in WAIT, or a kill from REQ-023: set kill flag; the next response is discarded (no HOLD); then REQ with the new PC; kill cleared on that response.
REQ-025 Redirect in HOLD: drop out_valid next cycle, PC<=redirect_pc, go to REQ; redirect wins over a simultaneous out fire (PC not incremented).
REQ-026 Redirect and imem_resp_valid in the same WAIT cycle: the response SHALL be discarded and the redirect taken.
REQ-027 Misaligned PC (PC[1:0]!=0) in REQ: no memory request; go directly to HOLD with out_fault=1 and out_inst=32'h0000_0013.
REQ-028 Bus error: out_fault=1, out_inst=32'h0000_0013 (NOP), out_pc=faulting PC; after consume, PC+4 per REQ-020 (trap redirect expected from execute).
REQ-029 At most one request SHALL be outstanding; any imem_resp_valid outside WAIT SHALL be ignored.

Reset
REQ-030 While rst=1: state=REQ, PC=RESET_PC, kill=0, out_valid=0, out_pc=RESET_PC, out_inst=32'h0000_0013, out_fault=0; imem_req_valid=0 during the reset cycle.
REQ-031 Reset mid-transaction SHALL abandon it; a response arriving after reset deasserts while the FSM is in REQ SHALL be ignored.

Verification
REQ-032 Reset release, zero-wait memory returning 32'h0010_0093, out_ready=1: first req addr 8000_0000; out_valid in cycle 3 with out_pc 8000_0000; next req addr 8000_0004.
REQ-033 Backpressure: out_ready=0 for 5 cycles in HOLD: out_inst/out_pc stable; no new request; one consume then addr +4.
REQ-034 Redirect to 8000_0100 in WAIT: the stale response is dropped (out_valid stays 0); next req addr 8000_0100.
REQ-035 Redirect and out fire in the same HOLD cycle, target 8000_0020: next req addr 8000_0020, not PC+4.
REQ-036 imem_resp_err=1: out_fault=1 and out_inst=0000_0013; redirect_pc=8000_0002: no request issued, out_fault=1 in HOLD.
REQ-037 PC=FFFF_FFFC consumed: next req addr 0000_0000.
